// File: rtl/store_buffer_if.sv
// Pipeline/memory-facing bundle of the store buffer: store and load handshakes plus
// the data-memory port. The buffer connects through the slave modport.
interface store_buffer_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;
    logic              empty;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_data, ld_stall, mem_addr, mem_wdata, mem_write, mem_read, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_data, ld_stall, mem_addr, mem_wdata, mem_write, mem_read, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Circular write buffer between MEM stage and data memory; drains on load-free cycles.
// Define STBUF_FORWARD_EN to forward exact-address buffered data to loads.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    store_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    logic             hit_found;
    logic [PTR_W-1:0] scan_slot;
`ifdef STBUF_FORWARD_EN
    logic              hit_exact;
    logic [DATA_W-1:0] hit_data;
`endif

    function automatic logic overlaps(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return diff < ADDR_W'(8);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.st_valid && !full;
    assign pop   = !empty && !bus.ld_valid;

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (push) begin
            ent_addr_d[wr_ptr_q] = bus.st_addr;
            ent_data_d[wr_ptr_q] = bus.st_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Walk oldest to youngest so the youngest overlapping entry is the one left standing.
    always_comb begin
        hit_found = 1'b0;
        scan_slot = rd_ptr_q;
`ifdef STBUF_FORWARD_EN
        hit_exact = 1'b0;
        hit_data  = '0;
`endif
        for (int unsigned age = 0; age < DEPTH; age++) begin
            scan_slot = rd_ptr_q + PTR_W'(age);
            if ((CNT_W'(age) < count_q) && overlaps(ent_addr_q[scan_slot], bus.ld_addr)) begin
                hit_found = 1'b1;
`ifdef STBUF_FORWARD_EN
                hit_exact = (ent_addr_q[scan_slot] == bus.ld_addr);
                hit_data  = ent_data_q[scan_slot];
`endif
            end
        end
    end

`ifdef STBUF_FORWARD_EN
    assign bus.ld_stall = bus.ld_valid && hit_found && !hit_exact;
    assign bus.ld_data  = (hit_found && hit_exact) ? hit_data : bus.mem_rdata;
`else
    assign bus.ld_stall = bus.ld_valid && hit_found;
    assign bus.ld_data  = bus.mem_rdata;
`endif

    assign bus.st_ready  = !full;
    assign bus.empty     = empty;
    assign bus.mem_write = pop;
    assign bus.mem_read  = bus.ld_valid;
    assign bus.mem_addr  = bus.ld_valid ? bus.ld_addr : ent_addr_q[rd_ptr_q];
    assign bus.mem_wdata = ent_data_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: driver predicts per-cycle and drain responses from a
// queue-based buffer model and a golden memory; monitors compare on the falling edge.
module tb_store_buffer;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MEM_BYTES = 512;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } st_t;

    typedef struct {
        bit          ld_chk;
        bit          stall;
        logic [63:0] data;
        logic [63:0] maddr;
        bit          ready;
        bit          empty;
        bit          wr;
        bit          rd;
    } exp_t;

    st_t  sbq[$];
    st_t  drain_q[$];
    exp_t exp_q[$];

    logic [7:0] mem  [MEM_BYTES];
    logic [7:0] gmem [MEM_BYTES];

    int n_vec = 0;
    int n_err = 0;
    bit last_acc;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Data memory: combinational read, write captured on the rising edge.
    always_comb begin
        bus.mem_rdata = '0;
        for (int b = 0; b < 8; b++)
            bus.mem_rdata[b*8 +: 8] = mem[9'(bus.mem_addr[8:0] + 9'(b))];
    end

    initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (bus.mem_write)
                for (int b = 0; b < 8; b++)
                    mem[9'(bus.mem_addr[8:0] + 9'(b))] = bus.mem_wdata[b*8 +: 8];
        end
    end

    function automatic logic [63:0] gmem_read(input logic [63:0] a);
        logic [63:0] r;
        logic [63:0] p;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            p = a + 64'(b);
            r[b*8 +: 8] = gmem[p[8:0]];
        end
        return r;
    endfunction

    function automatic void gmem_write(input st_t s);
        logic [63:0] p;
        for (int b = 0; b < 8; b++) begin
            p = s.addr + 64'(b);
            gmem[p[8:0]] = s.data[b*8 +: 8];
        end
    endfunction

    // Two 8-byte windows intersect, measured without wrapping past the top of the address space.
    function automatic bit near(input logic [63:0] x, input logic [63:0] y);
        logic [64:0] xe, ye;
        xe = {1'b0, x};
        ye = {1'b0, y};
        return (xe < ye + 65'd8) && (ye < xe + 65'd8);
    endfunction

    function automatic void model_load(input logic [63:0] a, output bit stall, output logic [63:0] d);
        stall = 1'b0;
        d = gmem_read(a);
        for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (near(sbq[i].addr, a)) begin
`ifdef STBUF_FORWARD_EN
                if (sbq[i].addr == a) d = sbq[i].data;
                else stall = 1'b1;
`else
                stall = 1'b1;
`endif
                break;
            end
        end
    endfunction

    // Called at posedge+1; drives one cycle, predicts it, advances the model past the edge.
    task automatic cycle(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                         input bit lv, input logic [63:0] la);
        exp_t e;
        st_t  s;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        e.ready  = (sbq.size() < DEPTH);
        e.empty  = (sbq.size() == 0);
        e.wr     = (sbq.size() > 0) && !lv;
        e.rd     = lv;
        e.ld_chk = lv;
        e.maddr  = la;
        e.stall  = 1'b0;
        e.data   = '0;
        if (lv) model_load(la, e.stall, e.data);
        exp_q.push_back(e);
        last_acc = sv && e.ready;
        if (e.wr) gmem_write(sbq.pop_front());
        if (last_acc) begin
            s.addr = sa;
            s.data = sd;
            sbq.push_back(s);
            drain_q.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic load(input logic [63:0] la);
        cycle(1'b0, '0, '0, 1'b1, la);
    endtask

    task automatic drain_idle();
        int guard = 0;
        while (sbq.size() > 0 && guard < int'(2 * DEPTH)) begin
            idle();
            guard++;
        end
        idle();
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = 64'(8 * $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(1, 7));
        return a;
    endfunction

    // Monitor: per-cycle expectations and the drain stream.
    initial begin
        forever begin
            exp_t e;
            st_t  d;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bit("st_ready", bus.st_ready, e.ready);
                check_bit("empty", bus.empty, e.empty);
                check_bit("mem_write", bus.mem_write, e.wr);
                check_bit("mem_read", bus.mem_read, e.rd);
                if (e.ld_chk) begin
                    check_bit("ld_stall", bus.ld_stall, e.stall);
                    check64("mem_addr_load", bus.mem_addr, e.maddr);
                    if (!e.stall) check64("ld_data", bus.ld_data, e.data);
                end
            end
            if (bus.mem_write) begin
                if (drain_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: mem_write=1 addr %h, expected no write", bus.mem_addr);
                end else begin
                    d = drain_q.pop_front();
                    check64("drain_addr", bus.mem_addr, d.addr);
                    check64("drain_data", bus.mem_wdata, d.data);
                end
            end
        end
    end

    initial begin
        logic [63:0] d5, sa, sd, la;
        bit sv, lv, pend;
        int guard;

        for (int i = 0; i < int'(MEM_BYTES); i++) gmem[i] = init_byte(i);
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_st_ready", bus.st_ready, 1'b1);
        check_bit("rst_empty", bus.empty, 1'b1);
        check_bit("rst_mem_write", bus.mem_write, 1'b0);
        check_bit("rst_ld_stall", bus.ld_stall, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single store, drain, then read back through memory.
        cycle(1'b1, 64'd8, 64'h1122334455667788, 1'b0, '0);
        idle();
        idle();
        load(64'd8);
        idle();

        // Fill while a non-overlapping load blocks drains; fifth store waits.
        d5 = rand64();
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(8 * i), rand64(), 1'b1, 64'd64);
        cycle(1'b1, 64'd32, d5, 1'b1, 64'd64);
        cycle(1'b1, 64'd32, d5, 1'b1, 64'd64);
        guard = 0;
        do begin
            cycle(1'b1, 64'd32, d5, 1'b0, '0);
            guard++;
        end while (!last_acc && guard < 8);
        check_bit("fifth_store_accepted", last_acc, 1'b1);
        drain_idle();

        // Two stores to one address; youngest wins.
        cycle(1'b1, 64'd16, 64'hAAAA_0000_AAAA_0001, 1'b1, 64'd64);
        cycle(1'b1, 64'd16, 64'hBBBB_0000_BBBB_0002, 1'b1, 64'd64);
        load(64'd16);
        drain_idle();
        load(64'd16);

        // Partial overlap stalls until the bubble lets the entry drain.
        cycle(1'b1, 64'd8, 64'hC0C1_C2C3_C4C5_C6C7, 1'b1, 64'd64);
        load(64'd12);
        idle();
        load(64'd12);
        idle();

        // Overlap distance boundaries, including the top of the address space.
        cycle(1'b1, 64'd8, 64'h0123_4567_89AB_CDEF, 1'b1, 64'd64);
        load(64'd15);
        load(64'd16);
        load(64'd1);
        load(64'd0);
        load(64'd8);
        drain_idle();
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 64'd64);
        load(64'd0);
        load(64'hFFFF_FFFF_FFFF_FFF5);
        load(64'hFFFF_FFFF_FFFF_FFF4);
        drain_idle();

        // Enqueue and drain in the same cycle.
        cycle(1'b1, 64'd100, rand64(), 1'b1, 64'd200);
        cycle(1'b1, 64'd108, rand64(), 1'b1, 64'd200);
        cycle(1'b1, 64'd116, rand64(), 1'b0, '0);
        drain_idle();

        // Load and store together: load sees the contents before the enqueue.
        cycle(1'b1, 64'd40, 64'h5555_6666_7777_8888, 1'b1, 64'd40);
        load(64'd40);
        drain_idle();

        // Asynchronous reset with three stores still queued.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(48 + 8 * i), rand64(), 1'b1, 64'd200);
        idle();
        #2;
        reset_n = 1'b0;
        sbq.delete();
        drain_q.delete();
        #1;
        check_bit("arst_empty", bus.empty, 1'b1);
        check_bit("arst_st_ready", bus.st_ready, 1'b1);
        check_bit("arst_mem_write", bus.mem_write, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 64'd56;
        #1;
        check_bit("arst_ld_stall", bus.ld_stall, 1'b0);
        bus.ld_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_bit("arst_hold_mem_write", bus.mem_write, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) load(64'(48 + 8 * i));
        idle();

        // Randomized traffic; an unaccepted store is held unchanged.
        pend = 1'b0;
        sv = 1'b0;
        sa = '0;
        sd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!pend) begin
                sv = ($urandom_range(0, 99) < 45);
                sa = rand_addr();
                sd = rand64();
            end
            lv = ($urandom_range(0, 99) < 40);
            la = rand_addr();
            cycle(sv, sa, sd, lv, la);
            pend = sv && !last_acc;
        end
        drain_idle();
        check64("drain_queue_left", 64'(drain_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
